// File: rtl/dcache_rpt_pkg.sv
// Shared widths, stride-state encoding and table-entry layout for the D-cache RPT.
// The pctag field exists only when DC_RPT_PCTAG_EN is defined.
package dcache_rpt_pkg;

    localparam int unsigned RPT_ENTRIES = 16;
    localparam int unsigned RPT_PCTAG   = 8;
    localparam int unsigned RPT_STRIDE  = 4;
    localparam int unsigned RPT_IDX_W   = $clog2(RPT_ENTRIES);
    localparam int unsigned TAG_W       = 27;
    localparam int unsigned DROP_W      = 16;

    typedef enum logic [1:0] {
        RPT_INIT,
        RPT_TRANSIENT,
        RPT_STEADY,
        RPT_NOPRED
    } rpt_state_t;

    typedef struct packed {
        logic                  valid;
`ifdef DC_RPT_PCTAG_EN
        logic [RPT_PCTAG-1:0]  pctag;
`endif
        logic [TAG_W-1:0]      prev_tag;
        logic [RPT_STRIDE-1:0] stride;
        logic                  dir;
        rpt_state_t            state;
    } rpt_entry_t;

endpackage

// File: rtl/dcache_rpt_stride_calc.sv
// Combinational stride trainer: next table entry, candidate-fire flag and candidate tag.
// With DC_RPT_PCTAG_EN a hit also requires the stored PC tag to match.
module dcache_rpt_stride_calc
    import dcache_rpt_pkg::*;
(
    input  rpt_entry_t            entry,
    input  logic [TAG_W-1:0]      mem_tag,
`ifdef DC_RPT_PCTAG_EN
    input  logic [RPT_PCTAG-1:0]  pctag,
`endif
    input  logic                  sb_hit,
    output rpt_entry_t            next_entry_c,
    output logic                  fire_c,
    output logic [TAG_W-1:0]      cand_tag_c
);
    localparam int unsigned DW = TAG_W + 1;

    logic [DW-1:0] delta;
    logic [DW-1:0] mag;
    logic          hit;
    logic          dir;
    logic          overflow;
    logic          correct;

    // Signed tag delta in DW bits; the sign bit selects the magnitude path.
    always_comb begin
        delta    = {1'b0, mem_tag} - {1'b0, entry.prev_tag};
        mag      = delta[DW-1] ? (~delta + DW'(1)) : delta;
        dir      = !delta[DW-1] && (delta != '0);
        overflow = |mag[DW-1:RPT_STRIDE];
        correct  = !overflow && (mag[RPT_STRIDE-1:0] == entry.stride)
                   && (dir == entry.dir) && (mag != '0);
`ifdef DC_RPT_PCTAG_EN
        hit      = entry.valid && (entry.pctag == pctag);
`else
        hit      = entry.valid;
`endif
    end

    always_comb begin
        next_entry_c = entry;
        fire_c       = 1'b0;
        if (!hit) begin
            next_entry_c.valid    = 1'b1;
`ifdef DC_RPT_PCTAG_EN
            next_entry_c.pctag    = pctag;
`endif
            next_entry_c.prev_tag = mem_tag;
            next_entry_c.stride   = '0;
            next_entry_c.dir      = 1'b0;
            next_entry_c.state    = RPT_INIT;
        end else begin
            next_entry_c.prev_tag = mem_tag;
            if (overflow) begin
                next_entry_c.state = RPT_NOPRED;
            end else if (correct) begin
                next_entry_c.state = (entry.state == RPT_NOPRED) ? RPT_TRANSIENT : RPT_STEADY;
            end else begin
                case (entry.state)
                    RPT_INIT: begin
                        next_entry_c.state  = RPT_TRANSIENT;
                        next_entry_c.stride = mag[RPT_STRIDE-1:0];
                        next_entry_c.dir    = dir;
                    end
                    RPT_STEADY: begin
                        next_entry_c.state  = RPT_INIT;
                    end
                    default: begin
                        next_entry_c.state  = RPT_NOPRED;
                        next_entry_c.stride = mag[RPT_STRIDE-1:0];
                        next_entry_c.dir    = dir;
                    end
                endcase
            end
            // Fire on entering STEADY, or when a steady stream stops hitting the buffer.
            fire_c = (next_entry_c.state == RPT_STEADY) && (next_entry_c.stride != '0)
                     && ((entry.state != RPT_STEADY) || !sb_hit);
        end
    end

    always_comb begin
        cand_tag_c = next_entry_c.dir ? (mem_tag + TAG_W'(next_entry_c.stride))
                                      : (mem_tag - TAG_W'(next_entry_c.stride));
    end

endmodule

// File: rtl/dcache_rpt.sv
// Reference prediction table for the D-cache stride prefetcher: 2-stage read/update
// pipeline with write-to-read forwarding and a one-deep candidate slot. Option: DC_RPT_PCTAG_EN.
module dcache_rpt
    import dcache_rpt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_pc,
    input  logic [TAG_W-1:0]      mem_tag,
    input  logic                  mem_sb_hit,
    output logic                  rpt_pf_valid,
    output logic [TAG_W-1:0]      rpt_pf_tag,
    output logic [RPT_STRIDE-1:0] rpt_pf_stride,
    output logic                  rpt_pf_direction,
    input  logic                  rpt_pf_ready,
    output logic [DROP_W-1:0]     rpt_drop_cnt
);
    localparam int unsigned PCTAG_LSB = 2 + RPT_IDX_W;

    rpt_entry_t             tbl [RPT_ENTRIES];
    logic [RPT_ENTRIES-1:0] tbl_valid;

    logic [RPT_IDX_W-1:0]   s1_idx;
    rpt_entry_t             rd_entry_c;

    logic                   s2_valid;
    logic [RPT_IDX_W-1:0]   s2_idx;
    logic [TAG_W-1:0]       s2_tag;
    logic                   s2_sb_hit;
    rpt_entry_t             s2_entry;

    rpt_entry_t             wr_entry_c;
    logic                   fire_c;
    logic [TAG_W-1:0]       cand_tag_c;
    logic                   unused_pc;

    assign s1_idx = mem_pc[2 +: RPT_IDX_W];

`ifdef DC_RPT_PCTAG_EN
    logic [RPT_PCTAG-1:0]   s1_pctag;
    logic [RPT_PCTAG-1:0]   s2_pctag;
    assign s1_pctag  = mem_pc[PCTAG_LSB +: RPT_PCTAG];
    assign unused_pc = ^{mem_pc[31:PCTAG_LSB+RPT_PCTAG], mem_pc[1:0]};
`else
    assign unused_pc = ^{mem_pc[31:PCTAG_LSB], mem_pc[1:0]};
`endif

    // S1 read; a same-index S2 write in this cycle wins over the array.
    always_comb begin
        rd_entry_c       = tbl[s1_idx];
        rd_entry_c.valid = tbl_valid[s1_idx];
        if (s2_valid && (s2_idx == s1_idx)) begin
            rd_entry_c = wr_entry_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_idx    <= '0;
            s2_tag    <= '0;
            s2_sb_hit <= 1'b0;
            s2_entry  <= '0;
`ifdef DC_RPT_PCTAG_EN
            s2_pctag  <= '0;
`endif
        end else begin
            s2_valid <= mem_valid;
            if (mem_valid) begin
                s2_idx    <= s1_idx;
                s2_tag    <= mem_tag;
                s2_sb_hit <= mem_sb_hit;
                s2_entry  <= rd_entry_c;
`ifdef DC_RPT_PCTAG_EN
                s2_pctag  <= s1_pctag;
`endif
            end
        end
    end

    dcache_rpt_stride_calc u_calc (
        .entry        (s2_entry),
        .mem_tag      (s2_tag),
`ifdef DC_RPT_PCTAG_EN
        .pctag        (s2_pctag),
`endif
        .sb_hit       (s2_sb_hit),
        .next_entry_c (wr_entry_c),
        .fire_c       (fire_c),
        .cand_tag_c   (cand_tag_c)
    );

    // Valid bits carry the reset; entry payload is qualified by them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_valid <= '0;
        end else if (s2_valid) begin
            tbl_valid[s2_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s2_valid) begin
            tbl[s2_idx] <= wr_entry_c;
        end
    end

    // Candidate slot: oldest pending candidate is kept, newcomers are counted as drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_pf_valid     <= 1'b0;
            rpt_pf_tag       <= '0;
            rpt_pf_stride    <= '0;
            rpt_pf_direction <= 1'b0;
            rpt_drop_cnt     <= '0;
        end else if (s2_valid && fire_c) begin
            if (!rpt_pf_valid || rpt_pf_ready) begin
                rpt_pf_valid     <= 1'b1;
                rpt_pf_tag       <= cand_tag_c;
                rpt_pf_stride    <= wr_entry_c.stride;
                rpt_pf_direction <= wr_entry_c.dir;
            end else if (rpt_drop_cnt != '1) begin
                rpt_drop_cnt <= rpt_drop_cnt + DROP_W'(1);
            end
        end else if (rpt_pf_ready) begin
            rpt_pf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_rpt.sv
// Scoreboard bench for dcache_rpt: directed training scenarios then random traffic,
// checked against a behavioural per-PC stride model and a one-slot output model.
module tb_dcache_rpt;
    import dcache_rpt_pkg::*;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [RPT_STRIDE-1:0] stride;
        logic                  dir;
    } cand_t;

    typedef enum int {M_INIT, M_TRANS, M_STEADY, M_NOPRED} m_state_e;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  mem_valid;
    logic [31:0]           mem_pc;
    logic [TAG_W-1:0]      mem_tag;
    logic                  mem_sb_hit;
    logic                  rpt_pf_valid;
    logic [TAG_W-1:0]      rpt_pf_tag;
    logic [RPT_STRIDE-1:0] rpt_pf_stride;
    logic                  rpt_pf_direction;
    logic                  rpt_pf_ready;
    logic [DROP_W-1:0]     rpt_drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit        m_v      [RPT_ENTRIES];
    int        m_prev   [RPT_ENTRIES];
    int        m_stride [RPT_ENTRIES];
    bit        m_dir    [RPT_ENTRIES];
    m_state_e  m_st     [RPT_ENTRIES];
    int        m_pctag  [RPT_ENTRIES];
    bit        m_pipe_v;
    cand_t     m_pipe;
    bit        m_slot_v;
    cand_t     m_slot;
    int        m_drop;
    cand_t     exp_q [$];

    dcache_rpt dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid        (mem_valid),
        .mem_pc           (mem_pc),
        .mem_tag          (mem_tag),
        .mem_sb_hit       (mem_sb_hit),
        .rpt_pf_valid     (rpt_pf_valid),
        .rpt_pf_tag       (rpt_pf_tag),
        .rpt_pf_stride    (rpt_pf_stride),
        .rpt_pf_direction (rpt_pf_direction),
        .rpt_pf_ready     (rpt_pf_ready),
        .rpt_drop_cnt     (rpt_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < RPT_ENTRIES; i++) begin
            m_v[i] = 1'b0;
        end
        m_pipe_v = 1'b0;
        m_pipe   = '0;
        m_slot_v = 1'b0;
        m_slot   = '0;
        m_drop   = 0;
        exp_q.delete();
    endtask

    // Spec-level training rules applied to one committed access.
    task automatic model_access(input bit [31:0] pc, input bit [TAG_W-1:0] tag, input bit sb,
                                output bit fire, output cand_t c);
        int i, d, mag, s;
        bit dr, hit, ovf, cor;
        m_state_e prior, nxt;
        fire = 1'b0;
        c    = '0;
        i    = int'((pc >> 2) % RPT_ENTRIES);
        hit  = m_v[i];
`ifdef DC_RPT_PCTAG_EN
        if (m_pctag[i] != int'((pc >> (2 + RPT_IDX_W)) % (1 << RPT_PCTAG))) hit = 1'b0;
`endif
        if (!hit) begin
            m_v[i]      = 1'b1;
            m_prev[i]   = int'(tag);
            m_stride[i] = 0;
            m_dir[i]    = 1'b0;
            m_st[i]     = M_INIT;
            m_pctag[i]  = int'((pc >> (2 + RPT_IDX_W)) % (1 << RPT_PCTAG));
            return;
        end
        d     = int'(tag) - m_prev[i];
        dr    = d > 0;
        mag   = (d < 0) ? -d : d;
        ovf   = mag >= (1 << RPT_STRIDE);
        cor   = !ovf && mag == m_stride[i] && dr == m_dir[i] && mag != 0;
        prior = m_st[i];
        if (ovf) begin
            nxt = M_NOPRED;
        end else if (cor) begin
            nxt = (prior == M_NOPRED) ? M_TRANS : M_STEADY;
        end else begin
            case (prior)
                M_INIT:   nxt = M_TRANS;
                M_STEADY: nxt = M_INIT;
                default:  nxt = M_NOPRED;
            endcase
            if (prior != M_STEADY) begin
                m_stride[i] = mag;
                m_dir[i]    = dr;
            end
        end
        m_st[i]   = nxt;
        m_prev[i] = int'(tag);
        if (nxt == M_STEADY && m_stride[i] != 0 && (prior != M_STEADY || !sb)) begin
            fire     = 1'b1;
            s        = m_dir[i] ? m_stride[i] : -m_stride[i];
            c.tag    = TAG_W'(int'(tag) + s);
            c.stride = RPT_STRIDE'(m_stride[i]);
            c.dir    = m_dir[i];
        end
    endtask

    // One clock of stimulus; model advances by one cycle and commits after the edge.
    task automatic cycle(input bit v, input bit [31:0] pc, input bit [TAG_W-1:0] tag,
                         input bit sb, input bit rdy);
        bit    n_slot_v, n_push, n_pipe_v;
        cand_t n_slot, n_pipe;
        int    n_drop;
        n_slot_v = m_slot_v;
        n_slot   = m_slot;
        n_drop   = m_drop;
        n_push   = 1'b0;
        n_pipe_v = 1'b0;
        n_pipe   = '0;
        mem_valid    = v;
        mem_pc       = pc;
        mem_tag      = tag;
        mem_sb_hit   = sb;
        rpt_pf_ready = rdy;
        if (m_pipe_v) begin
            if (!m_slot_v || rdy) begin
                n_slot_v = 1'b1;
                n_slot   = m_pipe;
                n_push   = 1'b1;
            end else if (n_drop < 65535) begin
                n_drop++;
            end
        end else if (rdy) begin
            n_slot_v = 1'b0;
        end
        if (v) model_access(pc, tag, sb, n_pipe_v, n_pipe);
        @(posedge clk);
        #1;
        m_slot_v = n_slot_v;
        m_slot   = n_slot;
        m_drop   = n_drop;
        m_pipe_v = n_pipe_v;
        m_pipe   = n_pipe;
        if (n_push) exp_q.push_back(n_slot);
    endtask

    task automatic acc(input bit [31:0] pc, input bit [TAG_W-1:0] tag, input bit sb, input bit rdy);
        cycle(1'b1, pc, tag, sb, rdy);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 32'h0, '0, 1'b0, rdy);
    endtask

    task automatic reset_pulse();
        rst          = 1'b0;
        mem_valid    = 1'b0;
        mem_pc       = '0;
        mem_tag      = '0;
        mem_sb_hit   = 1'b0;
        rpt_pf_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_cand(input string name, input bit [TAG_W-1:0] tag, input int stride,
                            input bit dir);
        chk({name, "_valid"}, 32'(rpt_pf_valid), 32'h1);
        chk({name, "_tag"}, 32'(rpt_pf_tag), 32'(tag));
        chk({name, "_stride"}, 32'(rpt_pf_stride), 32'(stride));
        chk({name, "_dir"}, 32'(rpt_pf_direction), 32'(dir));
    endtask

    // Monitor: slot occupancy, drop count and every accepted candidate against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("mon_pf_valid", 32'(rpt_pf_valid), 32'(m_slot_v));
            chk("mon_drop_cnt", 32'(rpt_drop_cnt), 32'(m_drop));
            if (rpt_pf_valid && rpt_pf_ready) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_cand", 32'h1, 32'h0);
                end else begin
                    cand_t e;
                    e = exp_q.pop_front();
                    chk("mon_tag", 32'(rpt_pf_tag), 32'(e.tag));
                    chk("mon_stride", 32'(rpt_pf_stride), 32'(e.stride));
                    chk("mon_dir", 32'(rpt_pf_direction), 32'(e.dir));
                end
            end
        end
    end

    initial begin
        bit [31:0]      pcs [6];
        int             rs  [6];
        bit [TAG_W-1:0] lt  [6];
        bit [TAG_W-1:0] ov_tag;
        rst          = 1'b0;
        mem_valid    = 1'b0;
        mem_pc       = '0;
        mem_tag      = '0;
        mem_sb_hit   = 1'b0;
        rpt_pf_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rpt_pf_valid), 32'h0);
        chk("rst_tag", 32'(rpt_pf_tag), 32'h0);
        chk("rst_stride", 32'(rpt_pf_stride), 32'h0);
        chk("rst_dir", 32'(rpt_pf_direction), 32'h0);
        chk("rst_drop", 32'(rpt_drop_cnt), 32'h0);
        rst = 1'b1;
        idle(1'b0);

        // Ascending stride 2, then no refire on a buffer hit
        acc(32'h40, 27'h100, 1'b0, 1'b0);
        acc(32'h40, 27'h102, 1'b0, 1'b0);
        acc(32'h40, 27'h104, 1'b0, 1'b0);
        idle(1'b0);
        chk_cand("asc", 27'h106, 2, 1'b1);
        idle(1'b1);
        acc(32'h40, 27'h106, 1'b1, 1'b1);
        idle(1'b1);
        chk("asc_sbhit_nofire", 32'(rpt_pf_valid), 32'h0);

        // Descending stride 3, then stream lost refires
        acc(32'h44, 27'h200, 1'b0, 1'b1);
        acc(32'h44, 27'h1FD, 1'b0, 1'b1);
        acc(32'h44, 27'h1FA, 1'b0, 1'b1);
        idle(1'b0);
        chk_cand("desc", 27'h1F7, 3, 1'b0);
        acc(32'h44, 27'h1F7, 1'b0, 1'b1);
        idle(1'b0);
        chk_cand("desc_lost", 27'h1F4, 3, 1'b0);
        idle(1'b1);

        // STEADY broken by delta 5 keeps stride 2 and recovers
        acc(32'h48, 27'h300, 1'b0, 1'b1);
        acc(32'h48, 27'h302, 1'b0, 1'b1);
        acc(32'h48, 27'h304, 1'b0, 1'b1);
        acc(32'h48, 27'h309, 1'b0, 1'b1);
        acc(32'h48, 27'h30B, 1'b0, 1'b1);
        idle(1'b0);
        chk_cand("recover", 27'h30D, 2, 1'b1);
        idle(1'b1);

        // Overflowing delta goes to NOPRED with no candidate
        ov_tag = 27'h400 + TAG_W'(1 << RPT_STRIDE);
        acc(32'h4C, 27'h400, 1'b0, 1'b1);
        acc(32'h4C, ov_tag, 1'b0, 1'b1);
        idle(1'b1);
        chk("ovf_nofire", 32'(rpt_pf_valid), 32'h0);
        acc(32'h4C, ov_tag + 27'd1, 1'b0, 1'b1);
        acc(32'h4C, ov_tag + 27'd2, 1'b0, 1'b1);
        acc(32'h4C, ov_tag + 27'd3, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Two PCs fire while the consumer stalls: first kept, second dropped
        acc(32'h50, 27'h500, 1'b0, 1'b0);
        acc(32'h54, 27'h600, 1'b0, 1'b0);
        acc(32'h50, 27'h501, 1'b0, 1'b0);
        acc(32'h54, 27'h601, 1'b0, 1'b0);
        acc(32'h50, 27'h502, 1'b0, 1'b0);
        acc(32'h54, 27'h602, 1'b0, 1'b0);
        idle(1'b0);
        chk_cand("drop_kept", 27'h503, 1, 1'b1);
        chk("drop_cnt", 32'(rpt_drop_cnt), 32'h1);
        idle(1'b1);

        // Back-to-back same PC relies on forwarding
        acc(32'h58, 27'h10, 1'b0, 1'b1);
        acc(32'h58, 27'h11, 1'b0, 1'b1);
        acc(32'h58, 27'h12, 1'b0, 1'b1);
        idle(1'b0);
        chk_cand("b2b", 27'h13, 1, 1'b1);

        // Asynchronous reset with a candidate pending
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(rpt_pf_valid), 32'h0);
        chk("midrst_drop", 32'(rpt_drop_cnt), 32'h0);
        reset_pulse();
        acc(32'h58, 27'h14, 1'b0, 1'b1);
        acc(32'h58, 27'h15, 1'b0, 1'b1);
        idle(1'b1);
        chk("retrain_from_init", 32'(rpt_pf_valid), 32'h0);
        acc(32'h58, 27'h16, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Aliasing PCs on one index, alternating
        for (int k = 0; k < 6; k++) begin
            acc((k % 2 == 0) ? 32'h1C : 32'h101C, TAG_W'(32'h700 + 2 * k), 1'b0, 1'b1);
        end
        idle(1'b1);
        idle(1'b1);

        // Random traffic over a few PCs, including index aliases
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h1100;
        pcs[3] = 32'h10C; pcs[4] = 32'h2100; pcs[5] = 32'h118;
        for (int k = 0; k < 6; k++) begin
            rs[k] = int'($urandom_range(0, 8)) - 4;
            lt[k] = TAG_W'($urandom);
        end
        for (int n = 0; n < 3000; n++) begin
            int k, r, step;
            bit v;
            if ($urandom_range(0, 999) == 0) begin
                reset_pulse();
            end
            v = $urandom_range(0, 9) < 7;
            k = int'($urandom_range(0, 5));
            r = int'($urandom_range(0, 99));
            if (r < 70) step = rs[k];
            else if (r < 85) step = int'($urandom_range(0, 40)) - 20;
            else if (r < 92) step = ($urandom_range(0, 1) == 1) ? (1 << RPT_STRIDE) : -(1 << RPT_STRIDE);
            else begin
                rs[k] = int'($urandom_range(0, 10)) - 5;
                step  = rs[k];
            end
            if (v) lt[k] = lt[k] + TAG_W'(step);
            cycle(v, pcs[k], lt[k], $urandom_range(0, 3) == 0, $urandom_range(0, 99) < 65);
        end
        repeat (4) idle(1'b1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_rpt.md
Name: dcache_rpt

Overview:
- Reference Prediction Table (RPT) for the data-cache stride prefetcher.
- Sits directly upstream of the stream buffer. It observes committed D-cache accesses, trains a per-PC stride state machine, and issues prefetch candidates.
- Each candidate carries the starting line tag, stride magnitude and direction. The buffer controller consumes it and drives the buffer's evict/tag/stride/direction inputs.

Parameters:
- RPT_ENTRIES, 16, number of table entries (power of 2, direct-mapped, indexed by mem_pc[2 +: log2(RPT_ENTRIES)]).
- RPT_PCTAG, 8, PC tag bits stored per entry (bits just above the index); used only when the optional feature is compiled in.
- RPT_STRIDE, from params package, width of the stride magnitude field; shared with the stream buffer.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- mem_valid  in  1  one access observed this cycle
- mem_pc  in  32  PC of the load/store
- mem_tag  in  27  line tag of the accessed address (addr[31:5])
- mem_sb_hit  in  1  access was serviced by the stream buffer; qualifies mem_valid
- rpt_pf_valid  out  1  prefetch candidate pending
- rpt_pf_tag  out  27  first line tag to prefetch
- rpt_pf_stride  out  RPT_STRIDE  stride magnitude in lines
- rpt_pf_direction  out  1  1 = ascending, 0 = descending
- rpt_pf_ready  in  1  consumer accepts the candidate this cycle
- rpt_drop_cnt  out  16  saturating count of candidates dropped while one was pending

Behaviour:
- Reset (rst=0, async):
  - All entries invalid; update-stage register cleared.
  - rpt_pf_valid=0; rpt_pf_tag/stride/direction=0; rpt_drop_cnt=0.
- Entry fields: valid, pctag, prev_tag[26:0], stride[RPT_STRIDE-1:0], dir, state[1:0].
- States: INIT, TRANSIENT, STEADY, NOPRED.
- Pipeline, 2 stages:
  - S1 (cycle of mem_valid): read the entry at index and register {access, entry}.
  - S2: compute the new entry, write it back, and generate a candidate.
  - Candidate appears on rpt_pf_valid the cycle after S2: 2-cycle latency from mem_valid.
- Forwarding: if S2 writes the same index that S1 reads in the same cycle, S1 takes the S2 write data, not stale array data. Back-to-back accesses at one index must train identically to spaced accesses.
- Delta computation:
  - delta = mem_tag - prev_tag, computed in 28-bit signed arithmetic.
  - dir = (delta > 0); mag = |delta|.
  - overflow = mag >= 2^RPT_STRIDE.
  - correct = !overflow && mag == stride && dir == entry.dir && mag != 0.
- Miss (entry invalid, or pctag mismatch when the feature is enabled): allocate valid=1, prev_tag=mem_tag, stride=0, dir=0, state=INIT.
- Hit, correct: INIT->STEADY, TRANSIENT->STEADY, STEADY->STEADY, NOPRED->TRANSIENT. Stride and dir unchanged.
- Hit, incorrect:
  - INIT->TRANSIENT, stride/dir <= mag/dir.
  - TRANSIENT->NOPRED, stride/dir <= mag/dir.
  - STEADY->INIT, stride kept.
  - NOPRED->NOPRED, stride/dir <= mag/dir.
  - If overflow: next state is NOPRED regardless of current state, and stride is kept.
- prev_tag <= mem_tag on every hit.
- Candidate generation in S2: next state == STEADY and stride != 0, and either
  - (a) prior state != STEADY, or
  - (b) prior state == STEADY && !mem_sb_hit (stream lost).
- Candidate tag = dir ? mem_tag + stride : mem_tag - stride, zero-extended stride, 27-bit wrap-around permitted.
- Output handshake:
  - rpt_pf_valid holds with stable fields until rpt_pf_ready=1; it clears the cycle after acceptance.
  - A new candidate in the accept cycle is loaded directly, so valid stays 1.
  - A candidate arriving while one is pending and not accepted is dropped (oldest kept); rpt_drop_cnt increments, saturating at 0xFFFF.
- mem_valid=0: no read, no write, no state change.
- Reset mid-training: all entries invalidated at once; a pending candidate is discarded.

Optional Feature:
- Macro DC_RPT_PCTAG_EN.
- Defined: each entry stores mem_pc[RPT_PCTAG-1+2+log2(RPT_ENTRIES) : 2+log2(RPT_ENTRIES)], and a hit requires valid && pctag match. Aliasing PCs reallocate the entry.
- Undefined: no pctag storage; hit = valid only; aliasing PCs share and retrain the entry.

Decomposition:
- params package: RPT_ENTRIES, RPT_STRIDE, RPT_PCTAG.
- rv32i_types package: rpt_state_t enum {RPT_INIT, RPT_TRANSIENT, RPT_STEADY, RPT_NOPRED}; rpt_entry_t struct.
- One sub-module: rpt_stride_calc. Pure combinational; takes the entry and mem_tag, returns the next entry, candidate-fire flag and candidate tag. Unit-testable in isolation.

Test Plan:
- Same PC, tags 0x100, 0x102, 0x104 -> states INIT, TRANSIENT, STEADY. One candidate tag 0x106, stride 2, dir 1, 2 cycles after the third access. No candidate on the fourth access with mem_sb_hit=1.
- Descending tags 0x200, 0x1FD, 0x1FA -> candidate 0x1F7, stride 3, dir 0. A fourth access 0x1F7 with mem_sb_hit=0 -> new candidate 0x1F4.
- STEADY entry (stride 2), then access delta 5 -> state INIT, stride remains 2. Next delta 2 -> STEADY, fires again.
- Delta 2^RPT_STRIDE -> state NOPRED, no candidate. rpt_pf_ready=0 while two candidates fire from different PCs -> first held, rpt_drop_cnt=1.
- Back-to-back same-PC accesses on consecutive cycles, 0x10, 0x11, 0x12 -> forwarding yields STEADY and candidate 0x13. rst pulsed low mid-stream -> rpt_pf_valid=0 immediately; retraining starts from INIT.
- With DC_RPT_PCTAG_EN: two PCs aliasing one index alternate -> entry reallocated each access, no candidate. Without it -> shared entry trains/retrains per delta rules.
